// File: rtl/jesd204b_scrambler.sv
// ---------------------------------------------------------------------------
// jesd204b_scrambler
//
// Transmit-side JESD204B self-synchronous scrambler, polynomial
// 1 + x^14 + x^15. One DATA_WIDTH word is processed per accepted beat,
// MSB first (bit DATA_WIDTH-1 is the first bit in time). The 15-bit LFSR
// state carries across beats. The output stage is a single register slice.
//
// Optional build macro: JESD204B_SCRAMBLER_PRESET_EN
//   defined   : storage resets to SEED, and a reseed input is added
//   undefined : storage resets to zero, SEED is ignored
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   reseed     in   (preset build only) reload storage with SEED
//   en         in   1 = scramble, 0 = bypass; sampled with each accepted beat
//   in_valid   in   upstream word valid
//   in_ready   out  block can accept a word this cycle (combinational)
//   in         in   plaintext word [DATA_WIDTH-1:0]
//   out_valid  out  out holds a valid word
//   out_ready  in   downstream accepts out this cycle
//   out        out  scrambled (or bypassed) word [DATA_WIDTH-1:0], registered
//
// Handshake: a word moves across an interface on a rising edge where its
// valid and ready are both 1. in_ready = !out_valid || out_ready, so the
// output register accepts a new word whenever it is empty or being drained
// in the same cycle, giving full throughput with one cycle of latency.
// ---------------------------------------------------------------------------
module jesd204b_scrambler #(
    parameter int          DATA_WIDTH = 128,
    parameter logic [14:0] SEED       = 15'h7F80
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef JESD204B_SCRAMBLER_PRESET_EN
    input  logic                  reseed,
`endif
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
);

`ifdef JESD204B_SCRAMBLER_PRESET_EN
    localparam logic [14:0] RESET_STATE = SEED;
`else
    // Storage always starts from zero in this build; SEED has no effect.
    localparam logic [14:0] RESET_STATE = SEED & 15'h0000;
`endif

    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_out_valid;
    logic [14:0]           r_storage;

    logic                  w_accept;
    logic [14:0]           w_start;
    logic [14:0]           w_state;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_fb;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;

`ifdef JESD204B_SCRAMBLER_PRESET_EN
    // A reseed coinciding with an accept scrambles that beat from SEED.
    assign w_start = reseed ? SEED : r_storage;
`else
    assign w_start = r_storage;
`endif

    // Bit-serial LFSR unrolled across the word. The bit shifted into the
    // state is the output bit (scrambled, or the plain bit in bypass), so a
    // downstream descrambler stays in step even while scrambling is off.
    always_comb begin
        w_state = w_start;
        w_word  = '0;
        w_fb    = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            w_fb      = w_state[14] ^ w_state[13];
            w_word[i] = en ? (in[i] ^ w_fb) : in[i];
            w_state   = {w_state[13:0], w_word[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_storage   <= RESET_STATE;
        end else if (w_accept) begin
            r_out       <= w_word;
            r_out_valid <= 1'b1;
            r_storage   <= w_state;
        end else begin
            // Without an accept, a drained word empties the register; a
            // stalled word holds together with the storage.
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
`ifdef JESD204B_SCRAMBLER_PRESET_EN
            if (reseed) begin
                r_storage <= SEED;
            end
`endif
        end
    end

endmodule

// File: tb/tb_jesd204b_scrambler.sv
// ---------------------------------------------------------------------------
// tb_jesd204b_scrambler
//
// Directed bench for jesd204b_scrambler. A 16-bit instance covers the
// hand-computed vectors, back-pressure, mid-stream reset and (in the preset
// build) reseed. A 128-bit instance is looped through a descrambler model.
// ---------------------------------------------------------------------------
module tb_jesd204b_scrambler;

`ifdef JESD204B_SCRAMBLER_PRESET_EN
    localparam logic [14:0] INIT_STATE = 15'h7F80;
`else
    localparam logic [14:0] INIT_STATE = 15'h0000;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- 16-bit instance ----------------
    logic        en16, iv16, ir16, ov16, or16, reseed16;
    logic [15:0] din16, dout16;

    jesd204b_scrambler #(.DATA_WIDTH(16)) u_dut16 (
        .clk       (clk),
        .reset     (rst),
`ifdef JESD204B_SCRAMBLER_PRESET_EN
        .reseed    (reseed16),
`endif
        .en        (en16),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .in        (din16),
        .out_valid (ov16),
        .out_ready (or16),
        .out       (dout16)
    );

    // ---------------- 128-bit instance ----------------
    logic         en128, iv128, ir128, ov128, or128, reseed128;
    logic [127:0] din128, dout128;

    jesd204b_scrambler #(.DATA_WIDTH(128)) u_dut128 (
        .clk       (clk),
        .reset     (rst),
`ifdef JESD204B_SCRAMBLER_PRESET_EN
        .reseed    (reseed128),
`endif
        .en        (en128),
        .in_valid  (iv128),
        .in_ready  (ir128),
        .in        (din128),
        .out_valid (ov128),
        .out_ready (or128),
        .out       (dout128)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0]  exp_q[$];
    logic [127:0] lb_q[$];

    typedef struct {
        logic        en;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference scrambler, one bit at a time.
    function automatic logic [15:0] scr16(input logic e, input logic [15:0] d,
                                          input logic [14:0] s_in, output logic [14:0] s_out);
        logic [14:0] s;
        logic [15:0] o;
        s = s_in;
        o = '0;
        for (int i = 15; i >= 0; i--) begin
            o[i] = e ? (d[i] ^ s[14] ^ s[13]) : d[i];
            s    = {s[13:0], o[i]};
        end
        s_out = s;
        return o;
    endfunction

    // Reference descrambler: shifts in the received (scrambled) bit.
    function automatic logic [127:0] descr128(input logic [127:0] d,
                                              input logic [14:0] s_in, output logic [14:0] s_out);
        logic [14:0]  s;
        logic [127:0] o;
        s = s_in;
        o = '0;
        for (int i = 127; i >= 0; i--) begin
            o[i] = d[i] ^ s[14] ^ s[13];
            s    = {s[13:0], d[i]};
        end
        s_out = s;
        return o;
    endfunction

    // ---------------- driver ----------------
    task automatic beat16(input logic e, input logic [15:0] d);
        @(negedge clk);
        en16  = e;
        din16 = d;
        iv16  = 1'b1;
        @(negedge clk);
        iv16  = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- main test ----------------
    initial begin
        logic [14:0]  m_state, m_next, d_state;
        logic [15:0]  e_out;
        logic [15:0]  bp_words[8];
        logic         bp_en[8];
        logic [127:0] w128, exp128;
        int sent, got, cyc;

        rst = 1'b1;
        en16 = 1'b1; iv16 = 1'b0; or16 = 1'b1; din16 = '0; reseed16 = 1'b0;
        en128 = 1'b1; iv128 = 1'b0; or128 = 1'b1; din128 = '0; reseed128 = 1'b0;

        // Vector table: first three are hand-computed constants.
        vecs[0] = '{1'b1, 16'h8000, 16'h8003};
        vecs[1] = '{1'b1, 16'h0000, 16'h000A};
        vecs[2] = '{1'b0, 16'h1234, 16'h1234};
        vecs[3] = '{1'b1, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0000};
        vecs[5] = '{1'b0, 16'hABCD, 16'hABCD};
        vecs[6] = '{1'b1, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 16'h5A5A, 16'h0000};
        m_state = INIT_STATE;
        for (int i = 0; i < 8; i++) begin
            e_out = scr16(vecs[i].en, vecs[i].din, m_state, m_next);
            if (i >= 3 || INIT_STATE != 15'h0000) vecs[i].exp = e_out;
            m_state = m_next;
        end

        // Reset state, including in_ready during reset.
        repeat (3) @(negedge clk);
        check("rst_in_ready", ir16, 1'b1);
        check("rst_out_valid", ov16, 1'b0);
        check("rst_out", dout16, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", ir16, 1'b1);

        // Table-driven beats with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            beat16(vecs[i].en, vecs[i].din);
            check($sformatf("vec%0d_valid", i), ov16, 1'b1);
            check($sformatf("vec%0d_out", i), dout16, vecs[i].exp);
        end
        @(negedge clk);
        check("idle_drained", ov16, 1'b0);

        // Back-pressure: 8 words, random en per word, random out_ready.
        for (int i = 0; i < 8; i++) begin
            bp_words[i] = 16'($urandom_range(0, 65535));
            bp_en[i]    = 1'($urandom_range(0, 1));
            exp_q.push_back(scr16(bp_en[i], bp_words[i], m_state, m_next));
            m_state = m_next;
        end
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 200) begin
            iv16 = (sent < 8);
            if (sent < 8) begin
                din16 = bp_words[sent];
                en16  = bp_en[sent];
            end
            or16 = 1'($urandom_range(0, 1));
            #1;
            check("bp_in_ready", ir16, !(ov16 && !or16));
            if (ov16 && or16) begin
                check($sformatf("bp_word%0d", got), dout16, exp_q.pop_front());
                got++;
            end
            if (iv16 && ir16) sent++;
            @(negedge clk);
            cyc++;
        end
        check("bp_word_count", got, 8);
        iv16 = 1'b0;
        or16 = 1'b1;
        @(negedge clk);

        // Reset while a word is stalled at the output.
        or16 = 1'b0;
        beat16(1'b1, 16'hBEEF);
        check("stall_valid", ov16, 1'b1);
        rst  = 1'b1;
        iv16 = 1'b1;
        din16 = 16'h1111;
        @(negedge clk);
        check("midrst_out_valid", ov16, 1'b0);
        check("midrst_out", dout16, 16'h0000);
        rst  = 1'b0;
        iv16 = 1'b0;
        or16 = 1'b1;
        beat16(1'b1, 16'h8000);
        check("midrst_first_beat", dout16, vecs[0].exp);

`ifdef JESD204B_SCRAMBLER_PRESET_EN
        // Reseed without accept, then a beat from SEED.
        e_out = scr16(1'b1, 16'h0000, 15'h7F80, m_next);
        @(negedge clk);
        reseed16 = 1'b1;
        @(negedge clk);
        reseed16 = 1'b0;
        beat16(1'b1, 16'h0000);
        check("reseed_beat_a", dout16, e_out);
        @(negedge clk);
        reseed16 = 1'b1;
        @(negedge clk);
        reseed16 = 1'b0;
        beat16(1'b1, 16'h0000);
        check("reseed_beat_b", dout16, e_out);
        // Reseed coinciding with an accept.
        @(negedge clk);
        reseed16 = 1'b1;
        en16 = 1'b1;
        din16 = 16'h0000;
        iv16 = 1'b1;
        @(negedge clk);
        reseed16 = 1'b0;
        iv16 = 1'b0;
        check("reseed_with_accept", dout16, e_out);
`endif

        // Loopback: 128-bit scrambler into descrambler model.
        d_state = INIT_STATE;
        for (int k = 0; k < 1005; k++) begin
            if (ov128) begin
                exp128 = lb_q.pop_front();
                check("loopback", descr128(dout128, d_state, m_next), exp128);
                d_state = m_next;
            end
            if (k < 1000) begin
                w128 = {$urandom(), $urandom(), $urandom(), $urandom()};
                din128 = w128;
                iv128 = 1'b1;
                lb_q.push_back(w128);
            end else begin
                iv128 = 1'b0;
            end
            @(negedge clk);
        end
        check("loopback_drained", lb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
